// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM stage: access FSM states and the MEM/WB payload.
// The all-zero payload is the pipeline bubble.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] read_data;
        logic [31:0] alu_result;
        logic [4:0]  rd;
        logic        misalign_err;
        logic        bus_err;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_access_unit_mem_wb_reg.sv
// MEM/WB pipeline register. A bubble request loads all zeros, so a stalled
// MEM stage never hands a partial instruction to writeback.
module mem_wb_reg
    import mem_access_unit_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    bubble_i,
    input  mem_wb_t d_i,
    output mem_wb_t q_o
);

    mem_wb_t q_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= MEM_WB_BUBBLE;
        end else if (bubble_i) begin
            q_q <= MEM_WB_BUBBLE;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: runs the data-memory req/ack handshake with a timeout, stalls
// upstream while an access is pending, and feeds the MEM/WB register.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [31:0]       ALU_result_in,
    input  logic [31:0]       reg_read_data_2_in,
    input  logic [4:0]        EX_MEM_RegisterRd_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              mem_stall,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic [31:0]       mem_read_data_out,
    output logic [31:0]       ALU_result_out,
    output logic [4:0]        MEM_WB_RegisterRd_out,
    output logic              misalign_err,
    output logic              bus_err
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               timeout_q, timeout_d;
    logic               hold_regwrite_q, hold_regwrite_d;
    logic               hold_memtoreg_q, hold_memtoreg_d;
    logic [31:0]        hold_alu_q, hold_alu_d;
    logic [4:0]         hold_rd_q, hold_rd_d;

    logic    mem_op;
    logic    misaligned;
    logic    stall;
    logic    bubble;
    mem_wb_t wb_d;
    mem_wb_t wb_q;

    assign mem_op     = MemRead_in | MemWrite_in;
    assign misaligned = mem_op & (ALU_result_in[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rdata_q         <= '0;
            timeout_q       <= 1'b0;
            hold_regwrite_q <= 1'b0;
            hold_memtoreg_q <= 1'b0;
            hold_alu_q      <= '0;
            hold_rd_q       <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            req_q           <= req_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            rdata_q         <= rdata_d;
            timeout_q       <= timeout_d;
            hold_regwrite_q <= hold_regwrite_d;
            hold_memtoreg_q <= hold_memtoreg_d;
            hold_alu_q      <= hold_alu_d;
            hold_rd_q       <= hold_rd_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        req_d           = req_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        timeout_d       = timeout_q;
        hold_regwrite_d = hold_regwrite_q;
        hold_memtoreg_d = hold_memtoreg_q;
        hold_alu_d      = hold_alu_q;
        hold_rd_d       = hold_rd_q;
        stall           = 1'b0;
        bubble          = 1'b0;
        wb_d            = MEM_WB_BUBBLE;

        case (state_q)
            IDLE: begin
                if (mem_op && !misaligned) begin
                    // Write wins when both read and write are requested.
                    stall           = 1'b1;
                    bubble          = 1'b1;
                    req_d           = 1'b1;
                    we_d            = MemWrite_in;
                    addr_d          = ALU_result_in[ADDR_W-1:0];
                    wdata_d         = reg_read_data_2_in;
                    rdata_d         = '0;
                    cnt_d           = '0;
                    timeout_d       = 1'b0;
                    hold_regwrite_d = RegWrite_in;
                    hold_memtoreg_d = MemtoReg_in;
                    hold_alu_d      = ALU_result_in;
                    hold_rd_d       = EX_MEM_RegisterRd_in;
                    state_d         = WAIT;
                end else begin
                    wb_d.reg_write    = RegWrite_in & ~misaligned;
                    wb_d.mem_to_reg   = MemtoReg_in;
                    wb_d.alu_result   = ALU_result_in;
                    wb_d.rd           = EX_MEM_RegisterRd_in;
                    wb_d.misalign_err = misaligned;
                end
            end
            WAIT: begin
                stall  = 1'b1;
                bubble = 1'b1;
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    rdata_d = dmem_rdata;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // A timed-out access must not write back anything.
                wb_d.reg_write  = hold_regwrite_q & ~timeout_q;
                wb_d.mem_to_reg = hold_memtoreg_q;
                wb_d.read_data  = (we_q || timeout_q) ? 32'd0 : rdata_q;
                wb_d.alu_result = hold_alu_q;
                wb_d.rd         = hold_rd_q;
                wb_d.bus_err    = timeout_q;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_wb_reg u_mem_wb_reg (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (bubble),
        .d_i      (wb_d),
        .q_o      (wb_q)
    );

    // Gating with reset keeps the stall low during reset even if EX/MEM still presents a load.
    assign mem_stall             = stall & reset;
    assign dmem_req              = req_q;
    assign dmem_we               = we_q;
    assign dmem_addr             = addr_q;
    assign dmem_wdata            = wdata_q;
    assign RegWrite_out          = wb_q.reg_write;
    assign MemtoReg_out          = wb_q.mem_to_reg;
    assign mem_read_data_out     = wb_q.read_data;
    assign ALU_result_out        = wb_q.alu_result;
    assign MEM_WB_RegisterRd_out = wb_q.rd;
    assign misalign_err          = wb_q.misalign_err;
    assign bus_err               = wb_q.bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: ALU pass-through, load/store handshakes,
// misalignment, bus timeout and reset in the middle of an access.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        RegWrite_in;
    logic        MemtoReg_in;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic [31:0] ALU_result_in;
    logic [31:0] reg_read_data_2_in;
    logic [4:0]  EX_MEM_RegisterRd_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        RegWrite_out;
    logic        MemtoReg_out;
    logic [31:0] mem_read_data_out;
    logic [31:0] ALU_result_out;
    logic [4:0]  MEM_WB_RegisterRd_out;
    logic        misalign_err;
    logic        bus_err;

    int total;
    int bad;
    int waitCycles;

    mem_access_unit #(
        .ADDR_W  (32),
        .TIMEOUT (16),
        .CNT_W   (5)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .RegWrite_in           (RegWrite_in),
        .MemtoReg_in           (MemtoReg_in),
        .MemRead_in            (MemRead_in),
        .MemWrite_in           (MemWrite_in),
        .ALU_result_in         (ALU_result_in),
        .reg_read_data_2_in    (reg_read_data_2_in),
        .EX_MEM_RegisterRd_in  (EX_MEM_RegisterRd_in),
        .dmem_req              (dmem_req),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_wdata            (dmem_wdata),
        .dmem_ack              (dmem_ack),
        .dmem_rdata            (dmem_rdata),
        .mem_stall             (mem_stall),
        .RegWrite_out          (RegWrite_out),
        .MemtoReg_out          (MemtoReg_out),
        .mem_read_data_out     (mem_read_data_out),
        .ALU_result_out        (ALU_result_out),
        .MEM_WB_RegisterRd_out (MEM_WB_RegisterRd_out),
        .misalign_err          (misalign_err),
        .bus_err               (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rw, input logic mtr, input logic mr, input logic mw,
                                 input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
        RegWrite_in          = rw;
        MemtoReg_in          = mtr;
        MemRead_in           = mr;
        MemWrite_in          = mw;
        ALU_result_in        = alu;
        reg_read_data_2_in   = wd;
        EX_MEM_RegisterRd_in = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 5'd0);

        repeat (2) @(negedge clk);
        checkOutput("rst_req", dmem_req, 0);
        checkOutput("rst_stall", mem_stall, 0);
        checkOutput("rst_regwrite", RegWrite_out, 0);
        checkOutput("rst_alu", ALU_result_out, 0);
        reset = 1'b1;

        // ALU op passes straight through; a stray ack in IDLE is ignored.
        @(negedge clk);
        applyStimulus(1, 0, 0, 0, 32'h1234, 32'd0, 5'd5);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        #1;
        checkOutput("alu_stall", mem_stall, 0);
        checkOutput("alu_req", dmem_req, 0);
        @(negedge clk);
        checkOutput("alu_regwrite", RegWrite_out, 1);
        checkOutput("alu_rd", MEM_WB_RegisterRd_out, 5);
        checkOutput("alu_value", ALU_result_out, 32'h1234);
        checkOutput("alu_rdata", mem_read_data_out, 0);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;

        // Load at 0x40, ack on the third WAIT cycle.
        applyStimulus(1, 1, 1, 0, 32'h40, 32'd0, 5'd7);
        #1;
        checkOutput("ld_stall0", mem_stall, 1);
        checkOutput("ld_req0", dmem_req, 0);
        @(negedge clk);
        checkOutput("ld_stall1", mem_stall, 1);
        checkOutput("ld_req1", dmem_req, 1);
        checkOutput("ld_we", dmem_we, 0);
        checkOutput("ld_addr", dmem_addr, 32'h40);
        checkOutput("ld_bubble_rw", RegWrite_out, 0);
        @(negedge clk);
        checkOutput("ld_stall2", mem_stall, 1);
        checkOutput("ld_bubble_alu", ALU_result_out, 0);
        @(negedge clk);
        checkOutput("ld_stall3", mem_stall, 1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        checkOutput("ld_done_stall", mem_stall, 0);
        checkOutput("ld_done_req", dmem_req, 0);
        checkOutput("ld_done_bubble", mem_read_data_out, 0);
        @(negedge clk);
        checkOutput("ld_wb_rdata", mem_read_data_out, 32'hDEAD_BEEF);
        checkOutput("ld_wb_memtoreg", MemtoReg_out, 1);
        checkOutput("ld_wb_regwrite", RegWrite_out, 1);
        checkOutput("ld_wb_rd", MEM_WB_RegisterRd_out, 7);

        // Store at 0x44 with immediate ack.
        applyStimulus(0, 0, 0, 1, 32'h44, 32'hA5A5_A5A5, 5'd0);
        #1;
        checkOutput("st_stall0", mem_stall, 1);
        @(negedge clk);
        checkOutput("st_stall1", mem_stall, 1);
        checkOutput("st_req", dmem_req, 1);
        checkOutput("st_we", dmem_we, 1);
        checkOutput("st_wdata", dmem_wdata, 32'hA5A5_A5A5);
        checkOutput("st_addr", dmem_addr, 32'h44);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        checkOutput("st_done_stall", mem_stall, 0);
        checkOutput("st_done_req", dmem_req, 0);
        @(negedge clk);
        checkOutput("st_wb_alu", ALU_result_out, 32'h44);
        checkOutput("st_wb_rdata", mem_read_data_out, 0);
        checkOutput("st_wb_regwrite", RegWrite_out, 0);

        // Misaligned load at 0x42.
        applyStimulus(1, 1, 1, 0, 32'h42, 32'd0, 5'd9);
        #1;
        checkOutput("mis_stall", mem_stall, 0);
        checkOutput("mis_req", dmem_req, 0);
        @(negedge clk);
        checkOutput("mis_err", misalign_err, 1);
        checkOutput("mis_regwrite", RegWrite_out, 0);
        checkOutput("mis_rd", MEM_WB_RegisterRd_out, 9);
        checkOutput("mis_req_after", dmem_req, 0);
        applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        checkOutput("mis_pulse", misalign_err, 0);

        // Load with no ack: expect exactly 16 WAIT cycles then a bus error.
        applyStimulus(1, 1, 1, 0, 32'h80, 32'd0, 5'd3);
        #1;
        checkOutput("to_stall0", mem_stall, 1);
        waitCycles = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (dmem_req && mem_stall) waitCycles++;
        end
        checkOutput("to_wait_cycles", waitCycles, 16);
        @(negedge clk);
        checkOutput("to_done_req", dmem_req, 0);
        checkOutput("to_done_stall", mem_stall, 0);
        @(negedge clk);
        checkOutput("to_bus_err", bus_err, 1);
        checkOutput("to_regwrite", RegWrite_out, 0);
        checkOutput("to_rd", MEM_WB_RegisterRd_out, 3);
        applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        checkOutput("to_pulse", bus_err, 0);

        // Reset asserted in the second WAIT cycle.
        applyStimulus(1, 1, 1, 0, 32'h40, 32'd0, 5'd4);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rr_req_before", dmem_req, 1);
        reset = 1'b0;
        #1;
        checkOutput("rr_req", dmem_req, 0);
        checkOutput("rr_stall", mem_stall, 0);
        checkOutput("rr_regwrite", RegWrite_out, 0);
        checkOutput("rr_rd", MEM_WB_RegisterRd_out, 0);
        applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rr_idle_req", dmem_req, 0);
        checkOutput("rr_idle_stall", mem_stall, 0);
        applyStimulus(1, 0, 0, 0, 32'h55, 32'd0, 5'd6);
        #1;
        checkOutput("rr_alu_stall", mem_stall, 0);
        @(negedge clk);
        checkOutput("rr_alu_value", ALU_result_out, 32'h55);
        checkOutput("rr_alu_rd", MEM_WB_RegisterRd_out, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
